// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module : sram_pkg
// Brief  : Shared constants, FSM state type and byte-merge helper for the
//          parametrised dual-port SRAM (sram_dp_param, sram_init_seq).
// Rev    : 1.0  initial release
// ============================================================================
package sram_pkg;

  localparam int BYTE_W      = 8;
  // Widest word the merge helper supports; callers zero-extend into it and
  // truncate the result back to their own width.
  localparam int MAX_DATA_W  = 256;
  localparam int MAX_WMASK_W = MAX_DATA_W / BYTE_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } sram_state_t;

  // Replace byte i of old_word with byte i of new_word wherever mask[i] is set.
  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0]  old_word,
    input logic [MAX_DATA_W-1:0]  new_word,
    input logic [MAX_WMASK_W-1:0] mask
  );
    logic [MAX_DATA_W-1:0] result;
    result = old_word;
    for (int i = 0; i < MAX_WMASK_W; i++) begin
      if (mask[i]) begin
        result[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_init_seq.sv
`default_nettype none
// ============================================================================
// Module : sram_init_seq
// Brief  : CLEAR/READY sequencer. After reset it walks a counter across every
//          word of the array, requesting a zero write per cycle, then drops
//          busy and stays in READY until the next reset.
// Ports  : clk, rst       clock / async active-high reset
//          o_busy         high in CLEAR (including while rst is held)
//          o_clr_we       clear write request for this cycle
//          o_clr_addr     word being cleared this cycle
// Rev    : 1.0  initial release
// ============================================================================
module sram_init_seq
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  o_busy,
  output logic                  o_clr_we,
  output logic [ADDR_WIDTH-1:0] o_clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  sram_state_t           r_state;
  sram_state_t           w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_busy      = 1'b0;
    o_clr_we    = 1'b0;
    o_clr_addr  = r_cnt;
    case (r_state)
      CLEAR: begin
        o_busy   = 1'b1;
        o_clr_we = 1'b1;
        // The edge that clears the last word also leaves CLEAR, so busy is
        // high for exactly RAM_DEPTH edges.
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = READY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
        end
      end
      READY: begin
        w_state_nxt = READY;
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sram_dp_param.sv
`default_nettype none
// ============================================================================
// Module : sram_dp_param
// Brief  : Parametrised behavioural 1RW + 1R dual-port SRAM with byte write
//          mask, registered/held read outputs and a post-reset hardware clear.
// Ports  : clk, rst              clock / async active-high reset
//          csb0, web0            port 0 select / write enable (active low)
//          wmask0, addr0, din0   port 0 byte mask, address, write data
//          dout0                 port 0 registered read data
//          csb1, addr1           port 1 (read-only) select / address
//          dout1                 port 1 registered read data
//          busy                  reset or clear in progress; requests ignored
// Macro  : SRAM_BYPASS_EN - when defined, a port 1 read colliding with a
//          port 0 write returns the merged (new) word; otherwise the old word.
// Note   : DATA_WIDTH must be a multiple of 8 and at most sram_pkg::MAX_DATA_W.
// Rev    : 1.0  initial release
// ============================================================================
module sram_dp_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int RAM_DEPTH   = 1 << ADDR_WIDTH,
  parameter int WMASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   busy
);

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] r_dout0;
  logic [DATA_WIDTH-1:0] r_dout1;

  logic                  w_busy;
  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;

  logic                  w_a0_ok;
  logic                  w_a1_ok;
  logic                  w_p0_wr;
  logic                  w_p0_rd;
  logic                  w_p1_rd;
  logic [DATA_WIDTH-1:0] w_old0;
  logic [DATA_WIDTH-1:0] w_old1;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_p1_data;

  sram_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH)
  ) u_init_seq (
    .clk        (clk),
    .rst        (rst),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  // RAM_DEPTH may be smaller than the address space; anything above it is
  // treated as unmapped (writes dropped, reads return zero).
  assign w_a0_ok = (32'(addr0) < 32'(RAM_DEPTH));
  assign w_a1_ok = (32'(addr1) < 32'(RAM_DEPTH));

  assign w_p0_wr = !w_busy && !csb0 && !web0 && w_a0_ok;
  assign w_p0_rd = !w_busy && !csb0 &&  web0;
  assign w_p1_rd = !w_busy && !csb1;

  assign w_old0 = w_a0_ok ? r_mem[addr0] : '0;
  assign w_old1 = w_a1_ok ? r_mem[addr1] : '0;

  assign w_merged = DATA_WIDTH'(merge_bytes(MAX_DATA_W'(w_old0),
                                            MAX_DATA_W'(din0),
                                            MAX_WMASK_W'(wmask0)));

`ifdef SRAM_BYPASS_EN
  logic w_coll;
  assign w_coll    = w_p0_wr && w_p1_rd && (addr0 == addr1);
  assign w_p1_data = w_coll ? w_merged : w_old1;
`else
  // Read-before-write: the array update lands after this edge, so port 1
  // naturally sees the old word on a collision.
  assign w_p1_data = w_old1;
`endif

  // Array storage carries no reset; the clear sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_p0_wr) begin
      r_mem[addr0] <= w_merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout0 <= '0;
      r_dout1 <= '0;
    end else begin
      if (w_p0_rd) begin
        r_dout0 <= w_old0;
      end
      if (w_p1_rd) begin
        r_dout1 <= w_p1_data;
      end
    end
  end

  assign dout0 = r_dout0;
  assign dout1 = r_dout1;
  assign busy  = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_sram_dp_param.sv
`default_nettype none
// ============================================================================
// Module : tb_sram_dp_param
// Brief  : Directed self-checking bench for sram_dp_param. Two instances share
//          the same stimulus: u_dut (RAM_DEPTH 16) and u_dut12 (RAM_DEPTH 12).
// Rev    : 1.0  initial release
// ============================================================================
module tb_sram_dp_param;

  logic        clk;
  logic        rst;
  logic        csb0;
  logic        web0;
  logic [3:0]  wmask0;
  logic [3:0]  addr0;
  logic [31:0] din0;
  logic        csb1;
  logic [3:0]  addr1;

  logic [31:0] dout0_a, dout1_a, dout0_b, dout1_b;
  logic        busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  sram_dp_param #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4),
    .RAM_DEPTH  (16)
  ) u_dut (
    .clk (clk), .rst (rst),
    .csb0 (csb0), .web0 (web0), .wmask0 (wmask0), .addr0 (addr0), .din0 (din0),
    .dout0 (dout0_a),
    .csb1 (csb1), .addr1 (addr1), .dout1 (dout1_a),
    .busy (busy_a)
  );

  sram_dp_param #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4),
    .RAM_DEPTH  (12)
  ) u_dut12 (
    .clk (clk), .rst (rst),
    .csb0 (csb0), .web0 (web0), .wmask0 (wmask0), .addr0 (addr0), .din0 (din0),
    .dout0 (dout0_b),
    .csb1 (csb1), .addr1 (addr1), .dout1 (dout1_b),
    .busy (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = 4'h0; din0 = 32'h0;
    csb1 = 1'b1; addr1 = 4'h0;
  endtask

  task automatic write0(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
  endtask

  task automatic read0(input logic [3:0] a);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a; wmask0 = 4'h0;
  endtask

  task automatic read1(input logic [3:0] a);
    csb1 = 1'b0; addr1 = a;
  endtask

  // Release reset and check busy across the whole clear window of both DUTs.
  task automatic release_and_clear();
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("busy16_e%0d", k), {31'b0, busy_a}, (k < 16) ? 32'd1 : 32'd0);
      chk($sformatf("busy12_e%0d", k), {31'b0, busy_b}, (k < 12) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      idle();
      read0(4'(a));
      read1(4'(a));
      tick();
      chk($sformatf("%s_d0a_%0d", tag, a), dout0_a, 32'h0);
      chk($sformatf("%s_d1a_%0d", tag, a), dout1_a, 32'h0);
      chk($sformatf("%s_d0b_%0d", tag, a), dout0_b, 32'h0);
      chk($sformatf("%s_d1b_%0d", tag, a), dout1_b, 32'h0);
    end
    idle();
  endtask

  logic [31:0] exp_coll;

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", {31'b0, busy_a}, 32'd1);
    chk("rst_d0",   dout0_a, 32'h0);
    chk("rst_d1",   dout1_a, 32'h0);

    // Clear window after reset, then every word reads zero.
    release_and_clear();
    read_all_zero("init");

    // Full write then port 1 read.
    write0(4'd3, 32'hDEADBEEF, 4'hF);
    tick();
    idle();
    read1(4'd3);
    tick();
    chk("full_wr_d1", dout1_a, 32'hDEADBEEF);
    chk("full_wr_d0_hold", dout0_a, 32'h0);

    // Partial write: bytes 0 and 2 replaced.
    idle();
    write0(4'd3, 32'h11223344, 4'h5);
    tick();
    idle();
    read0(4'd3);
    tick();
    chk("part_wr_d0", dout0_a, 32'hDE22BE44);
    chk("part_wr_d0_b", dout0_b, 32'hDE22BE44);

    // Collision on addr 5 (currently zero); dout0 must hold during the write.
    idle();
    write0(4'd5, 32'hCAFEF00D, 4'hF);
    read1(4'd5);
    tick();
`ifdef SRAM_BYPASS_EN
    exp_coll = 32'hCAFEF00D;
`else
    exp_coll = 32'h00000000;
`endif
    chk("coll_d1", dout1_a, exp_coll);
    chk("coll_d1_b", dout1_b, exp_coll);
    chk("wr_d0_hold", dout0_a, 32'hDE22BE44);

    // Dual read of the same address returns the stored word on both ports.
    idle();
    read0(4'd5);
    read1(4'd5);
    tick();
    chk("dual_rd_d0", dout0_a, 32'hCAFEF00D);
    chk("dual_rd_d1", dout1_a, 32'hCAFEF00D);

    // Zero-mask write changes nothing.
    idle();
    write0(4'd5, 32'hFFFFFFFF, 4'h0);
    tick();
    idle();
    read1(4'd5);
    tick();
    chk("mask0_d1", dout1_a, 32'hCAFEF00D);

    // Address 13: valid on u_dut, out of range on u_dut12.
    idle();
    write0(4'd13, 32'h12345678, 4'hF);
    tick();
    idle();
    read0(4'd13);
    read1(4'd1);
    tick();
    chk("oor_d0_16", dout0_a, 32'h12345678);
    chk("oor_d0_12", dout0_b, 32'h0);
    chk("oor_alias1_12", dout1_b, 32'h0);
    idle();
    read1(4'd11);
    tick();
    chk("oor_alias11_12", dout1_b, 32'h0);

    // dout1 holds while port 1 is deselected.
    idle();
    read1(4'd3);
    tick();
    chk("hold_pre_d1", dout1_a, 32'hDE22BE44);
    idle();
    addr1 = 4'd5;
    for (int k = 0; k < 5; k++) begin
      read0(4'(k));
      tick();
      chk($sformatf("hold_d1_%0d", k), dout1_a, 32'hDE22BE44);
    end
    // Last port 0 read was addr 4 (zero); reload a non-zero word on port 0.
    idle();
    read0(4'd13);
    tick();
    chk("pre_rst_d0", dout0_a, 32'h12345678);

    // Asynchronous reset from READY: outputs clear before the next edge.
    idle();
    rst = 1'b1;
    #1;
    chk("arst_d0", dout0_a, 32'h0);
    chk("arst_d1", dout1_a, 32'h0);
    chk("arst_busy", {31'b0, busy_a}, 32'd1);
    tick();

    // Reset again after 5 clear cycles.
    rst = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("midclr_busy_pre", {31'b0, busy_a}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midclr_busy", {31'b0, busy_a}, 32'd1);
    chk("midclr_d0", dout0_a, 32'h0);
    chk("midclr_d1", dout1_a, 32'h0);
    tick();

    // Full clear restarts from address 0; prior data (3, 5, 13) must be gone.
    release_and_clear();
    read_all_zero("reclr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_dp_param.md
# sram_dp_param

Parametrised behavioural 1RW+1R dual-port SRAM for the tile's register-file and buffer storage, replacing the fixed 16x32 blackbox macro model. Adds a byte write mask, registered read outputs with hold, and a hardware clear sequence that zeroes the whole array after reset. It also defines collision behaviour between the two ports. It runs on a single clock and sits directly under the user-project top, between the SPI/command decoder and the datapath.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 4, address width.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words; may be less than 2^ADDR_WIDTH.
- WMASK_WIDTH, DATA_WIDTH/8, one mask bit per byte.

Ports:
- clk  in  1  single clock, rising edge; both ports use it.
- rst  in  1  reset, asynchronous, active-high.
- csb0  in  1  port 0 chip select, active low.
- web0  in  1  port 0 write enable, active low.
- wmask0  in  WMASK_WIDTH  port 0 byte write mask; bit i covers din0[8i+7:8i].
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH  port 0 write data.
- dout0  out  DATA_WIDTH  port 0 registered read data.
- csb1  in  1  port 1 (read-only) chip select, active low.
- addr1  in  ADDR_WIDTH  port 1 address.
- dout1  out  DATA_WIDTH  port 1 registered read data.
- busy  out  1  high while reset is asserted or the clear sequence is running; all port requests are ignored while high.

## Operation
- FSM states are CLEAR and READY.
- While rst is high: state CLEAR, clear counter 0, busy 1, dout0 0, dout1 0.
- CLEAR: each clk edge writes mem[cnt] = 0 and increments cnt. The edge that writes cnt == RAM_DEPTH-1 moves the FSM to READY and drops busy.
- READY, port 0 write (csb0=0, web0=0): for each i with wmask0[i]=1, mem[addr0] byte i = din0 byte i. Other bytes are unchanged. dout0 holds.
- READY, port 0 read (csb0=0, web0=1): dout0 = mem[addr0] after the edge.
- READY, port 1 read (csb1=0): dout1 = mem[addr1] after the edge.
- When a port is deselected, or busy is high after clear start, its dout holds its last value.
- A write with wmask0 = 0 leaves memory unchanged.
- Out-of-range addresses (addr >= RAM_DEPTH): writes are dropped and reads return 0.
- Collision (port 0 write and port 1 read to the same address in the same cycle): behaviour is set by the macro under Configuration.
- A port 0 read and a port 1 read to the same address both return the stored word.
- Reset asserted mid-CLEAR or mid-READY immediately forces the reset values above. After release the clear sequence restarts at address 0.

## Timing
- Read latency is 1 cycle: address sampled at edge N, dout valid after edge N and stable until the next read on that port.
- Write commits at the sampling edge. A read at edge N+1 of an address written at edge N sees the new data.
- busy is high for exactly RAM_DEPTH cycles after the first edge following rst deassertion.
- No combinational path from any input to any output.

## Configuration
- SRAM_BYPASS_EN defined: on a collision, dout1 receives the merged word (masked bytes from din0, the remaining bytes from the old word).
- SRAM_BYPASS_EN undefined: on a collision, dout1 receives the old word (read-before-write).
- Port 0 behaviour is identical in both builds.

## Structure
- Shared package sram_pkg holds:
  - BYTE_W = 8;
  - the FSM state enum typedef (CLEAR, READY);
  - a function that merges a write word into an old word under a byte mask, used by both the write path and the bypass path.
- Sub-module sram_init_seq contains the CLEAR/READY FSM and clear counter. It outputs busy plus the clear write enable and address.
- The top module owns the array, the port muxing and the output registers.

## Test plan
- Reset release, DATA_WIDTH=32, RAM_DEPTH=16 -> busy high for 16 cycles, then low. A read of every address returns 0x00000000 on both ports.
- Full write: addr0=3, din0=0xDEADBEEF, wmask0=0xF, then port 1 read of addr 3 -> dout1=0xDEADBEEF one cycle later.
- Partial write: write 0x11223344 with wmask0=0x5 over stored 0xDEADBEEF -> stored word reads 0xDE22BE44.
- Collision: port 0 write of 0xCAFEF00D (mask 0xF) and port 1 read of the same address holding 0x0 -> dout1=0xCAFEF00D with SRAM_BYPASS_EN, dout1=0x00000000 without it.
- Range and hold: RAM_DEPTH=12, write to addr 13 then read addr 13 -> dout0=0, memory unchanged. With csb1 high for 5 cycles, dout1 holds its previous value.
- Reset after 5 clear cycles -> dout0/dout1=0 and busy=1. After release, busy is high for the full RAM_DEPTH cycles and all words read 0.
